// File: rtl/edubos5_rf_ctrl.sv
// ---------------------------------------------------------------------------
// edubos5_rf_ctrl
//   Sequencer/arbiter placed in front of edubos5_rf. The register file has no
//   reset, so after rst this block sweeps INIT_VAL into every register (x0
//   included), one per cycle. Afterwards CPU read/write traffic is passed
//   straight through with zero added latency, and writes to x0 are dropped.
//
//   Optional feature, macro EDUBOS5_RF_DBG_EN:
//     When defined, a debug requester may take the RF ports for a single
//     access while the CPU is halted (states DBG and ACK). When undefined,
//     cpu_halted and every dbg_* port are absent and the FSM is INIT/RUN only.
//
// Parameters
//   DATA_W    register width
//   ADDR_W    register address width (RF depth is 2**ADDR_W)
//   INIT_VAL  value written into every register during the init sweep
//
// Ports
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   cpu_rs1_addr, cpu_rs2_addr   CPU read addresses
//   cpu_rd_addr, cpu_we,
//   cpu_wdat                     CPU writeback request
//   cpu_ready                    high once the init sweep is done (low in DBG/ACK)
//   rf_rs1_addr, rf_rs2_addr,
//   rf_rd_addr, rf_we, rf_wdat   drive the register file ports
//   rf_rs2                       RF rs2 read data (debug read path only)
//   cpu_halted                   CPU stalled, debug may take the ports  [DBG_EN]
//   dbg_req, dbg_we, dbg_addr,
//   dbg_wdat                     debug request, held until dbg_ack     [DBG_EN]
//   dbg_ack                      one-cycle completion pulse            [DBG_EN]
//   dbg_rdat                     registered debug read data            [DBG_EN]
// ---------------------------------------------------------------------------
module edubos5_rf_ctrl #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_rs1_addr,
  input  logic [ADDR_W-1:0] cpu_rs2_addr,
  input  logic [ADDR_W-1:0] cpu_rd_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdat,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] rf_rs1_addr,
  output logic [ADDR_W-1:0] rf_rs2_addr,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdat,
  input  logic [DATA_W-1:0] rf_rs2
`ifdef EDUBOS5_RF_DBG_EN
  ,
  input  logic              cpu_halted,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdat,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdat
`endif
);

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;
  localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] X0      = '0;

`ifdef EDUBOS5_RF_DBG_EN
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DBG  = 2'd2,
    ST_ACK  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1
  } state_t;
`endif

  state_t            state;
  logic [ADDR_W-1:0] cnt;

  // Sequencing FSM. cpu_ready is registered so that it is high exactly in
  // RUN: it rises on the edge that ends the last sweep cycle and drops on the
  // edge that enters a debug access. In the debug build the DBG cycle
  // captures rf_rs2 for reads, and ACK is a single cycle that never
  // re-samples dbg_req, which is what makes back-to-back accesses 3 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      cnt       <= '0;
      cpu_ready <= 1'b0;
`ifdef EDUBOS5_RF_DBG_EN
      dbg_ack   <= 1'b0;
      dbg_rdat  <= '0;
`endif
    end else begin
`ifdef EDUBOS5_RF_DBG_EN
      dbg_ack <= 1'b0;
`endif
      case (state)
        ST_INIT: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_MAX) begin
            state     <= ST_RUN;
            cpu_ready <= 1'b1;
          end
        end
        ST_RUN: begin
`ifdef EDUBOS5_RF_DBG_EN
          if (dbg_req && cpu_halted) begin
            state     <= ST_DBG;
            cpu_ready <= 1'b0;
          end
`endif
        end
`ifdef EDUBOS5_RF_DBG_EN
        ST_DBG: begin
          if (!dbg_we) begin
            dbg_rdat <= rf_rs2;
          end
          dbg_ack <= 1'b1;
          state   <= ST_ACK;
        end
        ST_ACK: begin
          state     <= ST_RUN;
          cpu_ready <= 1'b1;
        end
`endif
        default: begin
          state     <= ST_INIT;
          cnt       <= '0;
          cpu_ready <= 1'b0;
        end
      endcase
    end
  end

  // RF port steering. Addresses and write data default to the CPU so the
  // read and write paths add no latency; only the write enable is qualified
  // per state. INIT owns the write port; the DBG cycle owns rs2 and, for a
  // debug write, the write port (the CPU is halted then, so nothing is lost).
  always_comb begin
    rf_rs1_addr = cpu_rs1_addr;
    rf_rs2_addr = cpu_rs2_addr;
    rf_rd_addr  = cpu_rd_addr;
    rf_wdat     = cpu_wdat;
    rf_we       = 1'b0;
    case (state)
      ST_INIT: begin
        rf_we      = 1'b1;
        rf_rd_addr = cnt;
        rf_wdat    = INIT_VAL;
      end
      ST_RUN: begin
        rf_we = cpu_we && (cpu_rd_addr != X0);
      end
`ifdef EDUBOS5_RF_DBG_EN
      ST_DBG: begin
        rf_rs2_addr = dbg_addr;
        if (dbg_we) begin
          rf_rd_addr = dbg_addr;
          rf_wdat    = dbg_wdat;
          rf_we      = (dbg_addr != X0);
        end
      end
`endif
      default: begin
        rf_we = 1'b0;
      end
    endcase
  end

`ifndef EDUBOS5_RF_DBG_EN
  // Without the debug path the rs2 read data has no consumer.
  logic unused_rf_rs2;
  assign unused_rf_rs2 = ^rf_rs2;
`endif

endmodule

// File: tb/tb_edubos5_rf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_edubos5_rf_ctrl
//   Bench for edubos5_rf_ctrl with a behavioural register file attached
//   (synchronous write, combinational read). Expected RF writes and expected
//   debug acks are queued by the stimulus; a monitor pops and compares them
//   whenever the DUT asserts rf_we or dbg_ack. Debug scenarios are compiled
//   when EDUBOS5_RF_DBG_EN is defined.
// ---------------------------------------------------------------------------
module tb_edubos5_rf_ctrl;

  localparam int          DATA_W   = 32;
  localparam int          ADDR_W   = 5;
  localparam logic [31:0] INIT_VAL = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] cpu_rs1_addr;
  logic [ADDR_W-1:0] cpu_rs2_addr;
  logic [ADDR_W-1:0] cpu_rd_addr;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_wdat;
  logic              cpu_ready;
  logic [ADDR_W-1:0] rf_rs1_addr;
  logic [ADDR_W-1:0] rf_rs2_addr;
  logic [ADDR_W-1:0] rf_rd_addr;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdat;
  logic [DATA_W-1:0] rf_rs2;
  logic [DATA_W-1:0] rd1;
`ifdef EDUBOS5_RF_DBG_EN
  logic              cpu_halted;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdat;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdat;
`endif

  logic [DATA_W-1:0] rf_mem [2**ADDR_W];
  wr_t               exp_wr  [$];
  logic [DATA_W-1:0] exp_ack [$];
  bit                mon_en = 1'b0;
  int                checks = 0;
  int                errors = 0;

  edubos5_rf_ctrl #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_VAL (INIT_VAL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_rs1_addr (cpu_rs1_addr),
    .cpu_rs2_addr (cpu_rs2_addr),
    .cpu_rd_addr  (cpu_rd_addr),
    .cpu_we       (cpu_we),
    .cpu_wdat     (cpu_wdat),
    .cpu_ready    (cpu_ready),
    .rf_rs1_addr  (rf_rs1_addr),
    .rf_rs2_addr  (rf_rs2_addr),
    .rf_rd_addr   (rf_rd_addr),
    .rf_we        (rf_we),
    .rf_wdat      (rf_wdat),
    .rf_rs2       (rf_rs2)
`ifdef EDUBOS5_RF_DBG_EN
    ,
    .cpu_halted   (cpu_halted),
    .dbg_req      (dbg_req),
    .dbg_we       (dbg_we),
    .dbg_addr     (dbg_addr),
    .dbg_wdat     (dbg_wdat),
    .dbg_ack      (dbg_ack),
    .dbg_rdat     (dbg_rdat)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Behavioural register file: no reset, write on the rising edge,
  // combinational reads on both ports.
  always @(posedge clk) begin
    if (rf_we === 1'b1) rf_mem[rf_rd_addr] <= rf_wdat;
  end
  assign rd1    = rf_mem[rf_rs1_addr];
  assign rf_rs2 = rf_mem[rf_rs2_addr];

  // Write monitor: every rf_we cycle must match the oldest queued write.
  always @(negedge clk) begin
    if (mon_en && rf_we === 1'b1) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("[TB] FAIL rf_write unexpected: addr=%0d data=%h", rf_rd_addr, rf_wdat);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        if (e.addr !== rf_rd_addr || e.data !== rf_wdat) begin
          errors++;
          $display("[TB] FAIL rf_write: got addr=%0d data=%h, want addr=%0d data=%h",
                   rf_rd_addr, rf_wdat, e.addr, e.data);
        end
      end
    end
  end

`ifdef EDUBOS5_RF_DBG_EN
  // Ack monitor: every dbg_ack pulse must carry the oldest queued read data.
  always @(negedge clk) begin
    if (mon_en && dbg_ack === 1'b1) begin
      checks++;
      if (exp_ack.size() == 0) begin
        errors++;
        $display("[TB] FAIL dbg_ack unexpected: rdat=%h", dbg_rdat);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_ack.pop_front();
        if (dbg_rdat !== e) begin
          errors++;
          $display("[TB] FAIL dbg_rdat: got %h, want %h", dbg_rdat, e);
        end
      end
    end
  end
`endif

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic wr_t mkWr(input int addr, input logic [DATA_W-1:0] data);
    wr_t w;
    w.addr = ADDR_W'(addr);
    w.data = data;
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input int rd, input logic [DATA_W-1:0] wdat,
                               input int rs1, input int rs2);
    @(posedge clk); #1;
    cpu_we       = we;
    cpu_rd_addr  = ADDR_W'(rd);
    cpu_wdat     = wdat;
    cpu_rs1_addr = ADDR_W'(rs1);
    cpu_rs2_addr = ADDR_W'(rs2);
  endtask

  // Called at the start of the first cycle with rst=0: cpu_ready must stay
  // low for 32 cycles and be high in the 33rd.
  task automatic sweepCheck(input string name);
    for (int i = 0; i < 2**ADDR_W; i++) begin
      @(negedge clk);
      checkOutput({name, "_ready_low"}, {31'd0, cpu_ready}, 32'd0);
      @(posedge clk); #1;
    end
    cpu_we = 1'b0;
    @(negedge clk);
    checkOutput({name, "_ready_high"}, {31'd0, cpu_ready}, 32'd1);
  endtask

  task automatic queueSweep(input int last);
    for (int i = 0; i <= last; i++) exp_wr.push_back(mkWr(i, INIT_VAL));
  endtask

`ifdef EDUBOS5_RF_DBG_EN
  task automatic dbgWaitAck(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (dbg_ack === 1'b1) begin
        seen = 1'b1;
        checkOutput({name, "_ready_in_ack"}, {31'd0, cpu_ready}, 32'd0);
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s_ack_timeout: got no ack, want ack within 8 cycles", name);
    end
    @(posedge clk); #1;
    dbg_req = 1'b0;
  endtask

  task automatic dbgAccess(input string name, input logic we, input int addr,
                           input logic [DATA_W-1:0] wdat, input logic [DATA_W-1:0] exp_rdat);
    @(posedge clk); #1;
    if (we && addr != 0) exp_wr.push_back(mkWr(addr, wdat));
    exp_ack.push_back(exp_rdat);
    dbg_we   = we;
    dbg_addr = ADDR_W'(addr);
    dbg_wdat = wdat;
    dbg_req  = 1'b1;
    dbgWaitAck(name);
  endtask
`endif

  // Directed sequence.
  initial begin
    rst          = 1'b1;
    cpu_we       = 1'b1;
    cpu_rd_addr  = 5'd9;
    cpu_wdat     = 32'h5555_5555;
    cpu_rs1_addr = '0;
    cpu_rs2_addr = '0;
`ifdef EDUBOS5_RF_DBG_EN
    cpu_halted   = 1'b0;
    dbg_req      = 1'b0;
    dbg_we       = 1'b0;
    dbg_addr     = '0;
    dbg_wdat     = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", {31'd0, cpu_ready}, 32'd0);
    checkOutput("rst_sweep_addr", {27'd0, rf_rd_addr}, 32'd0);
`ifdef EDUBOS5_RF_DBG_EN
    checkOutput("rst_dbg_ack", {31'd0, dbg_ack}, 32'd0);
    checkOutput("rst_dbg_rdat", dbg_rdat, 32'd0);
`endif

    // Init sweep 0..31 while cpu_we is held high (it must be ignored).
    @(posedge clk); #1;
    queueSweep(31);
    rst    = 1'b0;
    mon_en = 1'b1;
    sweepCheck("init");

    // CPU write to x5, then read it back the next cycle on both ports.
    applyStimulus(1'b1, 5, 32'hDEAD_BEEF, 0, 0);
    exp_wr.push_back(mkWr(5, 32'hDEAD_BEEF));
    @(negedge clk);
    checkOutput("wr5_rf_we", {31'd0, rf_we}, 32'd1);
    applyStimulus(1'b0, 0, 32'h0, 5, 5);
    @(negedge clk);
    checkOutput("rd5_rs1_addr", {27'd0, rf_rs1_addr}, 32'd5);
    checkOutput("rd5_rs1", rd1, 32'hDEAD_BEEF);
    checkOutput("rd5_rs2", rf_rs2, 32'hDEAD_BEEF);

    // CPU write to x0 is dropped; x0 still holds INIT_VAL.
    applyStimulus(1'b1, 0, 32'h1234_5678, 5, 5);
    @(negedge clk);
    checkOutput("wr0_rf_we", {31'd0, rf_we}, 32'd0);
    applyStimulus(1'b0, 0, 32'h0, 0, 5);
    @(negedge clk);
    checkOutput("rd0_rs1", rd1, INIT_VAL);

    // Reset from RUN, then a second reset when the sweep count is 17.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    queueSweep(17);
    repeat (17) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_addr", {27'd0, rf_rd_addr}, 32'd17);
    @(posedge clk); #1;
    queueSweep(31);
    rst = 1'b0;
    sweepCheck("restart");
    applyStimulus(1'b0, 0, 32'h0, 5, 0);
    @(negedge clk);
    checkOutput("restart_x5_cleared", rd1, INIT_VAL);

`ifdef EDUBOS5_RF_DBG_EN
    // Debug write while the CPU runs: no ack, no RF write, CPU writes pass.
    @(posedge clk); #1;
    dbg_req  = 1'b1;
    dbg_we   = 1'b1;
    dbg_addr = 5'd7;
    dbg_wdat = 32'hCAFE_F00D;
    cpu_we      = 1'b1;
    cpu_rd_addr = 5'd3;
    cpu_wdat    = 32'h3333_3333;
    exp_wr.push_back(mkWr(3, 32'h3333_3333));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("dbg_wait_no_ack", {31'd0, dbg_ack}, 32'd0);
      @(posedge clk); #1;
      cpu_we = 1'b0;
    end
    exp_wr.push_back(mkWr(7, 32'hCAFE_F00D));
    exp_ack.push_back(32'h0);
    cpu_halted = 1'b1;
    dbgWaitAck("dbg_wr7");

    // Reads while halted, then a write to x0 that is acked but not written.
    dbgAccess("dbg_rd0", 1'b0, 0, 32'h0, INIT_VAL);
    dbgAccess("dbg_rd7", 1'b0, 7, 32'h0, 32'hCAFE_F00D);
    dbgAccess("dbg_wr0", 1'b1, 0, 32'hBAD0_BAD0, 32'hCAFE_F00D);
    cpu_halted = 1'b0;
    applyStimulus(1'b0, 0, 32'h0, 0, 7);
    @(negedge clk);
    checkOutput("dbg_x0_kept", rd1, INIT_VAL);
    checkOutput("dbg_x7_read", rf_rs2, 32'hCAFE_F00D);
    checkOutput("dbg_ready_back", {31'd0, cpu_ready}, 32'd1);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_wr.size() != 0 || exp_ack.size() != 0) begin
      errors++;
      $display("[TB] FAIL leftover_expected: got %0d writes and %0d acks outstanding, want 0",
               exp_wr.size(), exp_ack.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
